dmem_byte_access: RTL and testbench

DMEM_BYTE_ACCESS -- requirements
Module: dmem_byte_access

---
 rtl/dmem_byte_access_if.sv | 41 ++++
 rtl/dmem_byte_access.sv | 144 ++++++++++++++
 tb/tb_dmem_byte_access.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_byte_access_if.sv
// Request/response bus between a load/store unit and the byte-addressable
// data memory. The master issues requests and consumes responses; the slave
// (the memory) accepts requests and produces one response per request.
interface dmem_byte_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/dmem_byte_access.sv
// Byte-addressable RV32I data memory with one-cycle response latency.
// Supports LB/LH/LW/LBU/LHU and SB/SH/SW on a DEPTH_WORDS x 32 little-endian
// array. Addresses wrap modulo 4*DEPTH_WORDS bytes.
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword and
// word accesses; when undefined they are aligned down and executed normally.
module dmem_byte_access #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input logic              clk,
  input logic              rst_n,
  dmem_byte_access_if.slave bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Extract the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] ext_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {off, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    case (f3)
      F3_B:    r = 32'(b);
      F3_H:    r = 32'(h);
      F3_BU:   r = signed'({24'd0, sh[7:0]});
      F3_HU:   r = signed'({16'd0, sh[15:0]});
      default: r = signed'(sh);
    endcase
    return unsigned'(r);
  endfunction

  // Byte-enable mask for a store of the given width at the given lane offset.
  function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = 4'b0011 << off;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Storage starts zeroed at time zero; reset never touches it.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic             acc_p0;
  logic             legal_p0;
  logic             misal_p0;
  logic             err_p0;
  logic [1:0]       off_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [3:0]       be_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      rword_p0;
  logic [31:0]      rdata_p0;

  logic             vld_p1;
  logic [31:0]      rdata_p1;
  logic             err_p1;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:IDX_W+2];

  // ---- stage p0: request decode and combinational memory read ----
  assign bus.req_ready = !vld_p1 || bus.rsp_ready;
  assign acc_p0        = bus.req_valid && bus.req_ready && rst_n;
  assign idx_p0        = bus.req_addr[IDX_W+1:2];

  // Classify the request: legality, alignment, effective lane offset.
  always_comb begin
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: legal_p0 = 1'b1;
      F3_BU, F3_HU:     legal_p0 = !bus.req_we;
      default:          legal_p0 = 1'b0;
    endcase

    misal_p0 = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    err_p0 = !legal_p0 || misal_p0;
    off_p0 = bus.req_addr[1:0];
`else
    err_p0 = !legal_p0;
    case (bus.req_funct3[1:0])
      2'b01:   off_p0 = {bus.req_addr[1], 1'b0};
      2'b10:   off_p0 = 2'b00;
      default: off_p0 = bus.req_addr[1:0];
    endcase
`endif
  end

  // Store lanes and shifted data; load result from the word as it is now.
  always_comb begin
    be_p0    = (bus.req_we && !err_p0) ? store_mask(bus.req_funct3, off_p0) : 4'b0000;
    wdata_p0 = bus.req_wdata << {off_p0, 3'b000};
    rword_p0 = mem[idx_p0];
    rdata_p0 = (bus.req_we || err_p0) ? 32'd0
                                      : ext_load(rword_p0, bus.req_funct3, off_p0);
  end

  // Byte-lane writes at the accept edge; a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      for (int l = 0; l < 4; l++) begin
        if (be_p0[l]) mem[idx_p0][l*8 +: 8] <= wdata_p0[l*8 +: 8];
      end
    end
  end

  // ---- stage p1: response registers, held until consumed ----
  // Load a new response on accept, retire it on consume, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else if (acc_p0) begin
      vld_p1   <= 1'b1;
      rdata_p1 <= rdata_p0;
      err_p1   <= err_p0;
    end else if (bus.rsp_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;

endmodule

// File: tb/tb_dmem_byte_access.sv
// Directed bench for dmem_byte_access: reset behaviour, word and sub-word
// access, partial stores, backpressure, streaming, alignment handling,
// illegal codes, address wrap and reset with a pending response.
module tb_dmem_byte_access;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_byte_access_if bus ();

  dmem_byte_access #(.DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request with rsp_ready=1; returns the response seen one cycle later.
  task automatic xact(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic vl, output logic [31:0] rd, output logic er);
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    vl = bus.rsp_valid;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic test_reset();
    logic vl, er;
    logic [31:0] rd;
    rst_n = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b rdata=%h err=%b, want 0/00000000/0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    xact(1'b0, 3'b010, 32'h20, 32'd0, vl, rd, er);
    checks++;
    if (vl !== 1'b1 || rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_store_ignored: got vld=%b rdata=%h err=%b, want 1/00000000/0", vl, rd, er);
    end
  endtask

  task automatic test_word();
    logic vl, er;
    logic [31:0] rd;
    xact(1'b1, 3'b010, 32'h10, 32'h8081_7F22, vl, rd, er);
    checks++;
    if (vl !== 1'b1 || rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_response: got vld=%b rdata=%h err=%b, want 1/00000000/0", vl, rd, er);
    end
    xact(1'b0, 3'b010, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (vl !== 1'b1 || rd !== 32'h8081_7F22 || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_0x10: got vld=%b rdata=%h err=%b, want 1/80817f22/0", vl, rd, er);
    end
  endtask

  task automatic test_subword_load();
    logic vl, er;
    logic [31:0] rd;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000};
    logic [31:0] ad  [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h11};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F22,
                             32'h0000_8081, 32'hFFFF_8081, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, f3[i], ad[i], 32'd0, vl, rd, er);
      checks++;
      if (vl !== 1'b1 || rd !== exp[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL subword_load[%0d] f3=%b addr=%h: got vld=%b rdata=%h err=%b, want 1/%h/0",
                 i, f3[i], ad[i], vl, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic vl, er;
    logic [31:0] rd;
    xact(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA, vl, rd, er);
    xact(1'b0, 3'b010, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'h8081_AA22 || er !== 1'b0) begin
      errors++;
      $display("FAIL sb_0x11: got rdata=%h err=%b, want 8081aa22/0", rd, er);
    end
    xact(1'b1, 3'b001, 32'h12, 32'hFFFF_1234, vl, rd, er);
    xact(1'b0, 3'b010, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'h1234_AA22 || er !== 1'b0) begin
      errors++;
      $display("FAIL sh_0x12: got rdata=%h err=%b, want 1234aa22/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic        we  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3  [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b001, 3'b010};
    logic [31:0] ad  [8] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h45, 32'h44, 32'h42, 32'h40};
    logic [31:0] wd  [8] = '{32'h1122_3344, 32'd0, 32'h5566_7788, 32'd0,
                             32'h0000_00CC, 32'd0, 32'h0000_BEEF, 32'd0};
    logic [31:0] exp [8] = '{32'd0, 32'h1122_3344, 32'd0, 32'h5566_7788,
                             32'd0, 32'h5566_CC88, 32'd0, 32'hBEEF_3344};
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we[0];
    bus.req_funct3 = f3[0];
    bus.req_addr   = ad[0];
    bus.req_wdata  = wd[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        bus.req_we     = we[i+1];
        bus.req_funct3 = f3[i+1];
        bus.req_addr   = ad[i+1];
        bus.req_wdata  = wd[i+1];
      end else begin
        bus.req_valid  = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp[i] || bus.rsp_err !== 1'b0 ||
          bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got vld=%b rdata=%h err=%b rdy=%b, want 1/%h/0/1",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, exp[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got vld=%b want 0 after 9 cycles", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    bus.req_addr   = 32'h44;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_AA22 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got vld=%b rdata=%h rdy=%b, want 1/1234aa22/0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
      if (k < 2) @(posedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5566_CC88 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL consume_and_accept: got vld=%b rdata=%h err=%b, want 1/5566cc88/0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
  endtask

  task automatic test_misalign();
    logic vl, er;
    logic [31:0] rd;
    logic        exp_err;
    logic [31:0] exp_w0;
    logic [31:0] exp_lh;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_err = 1'b1;
    exp_w0  = 32'd0;
    exp_lh  = 32'd0;
`else
    exp_err = 1'b0;
    exp_w0  = 32'hFFFF_FFFF;
    exp_lh  = 32'hFFFF_AA22;
`endif
    xact(1'b1, 3'b010, 32'h2, 32'hFFFF_FFFF, vl, rd, er);
    checks++;
    if (er !== exp_err || rd !== 32'd0) begin
      errors++;
      $display("FAIL sw_misaligned_err: got err=%b rdata=%h, want %b/00000000", er, rd, exp_err);
    end
    xact(1'b0, 3'b010, 32'h0, 32'd0, vl, rd, er);
    checks++;
    if (rd !== exp_w0 || er !== 1'b0) begin
      errors++;
      $display("FAIL word0_after_misaligned: got rdata=%h err=%b, want %h/0", rd, er, exp_w0);
    end
    xact(1'b0, 3'b001, 32'h11, 32'd0, vl, rd, er);
    checks++;
    if (rd !== exp_lh || er !== exp_err) begin
      errors++;
      $display("FAIL lh_misaligned: got rdata=%h err=%b, want %h/%b", rd, er, exp_lh, exp_err);
    end
  endtask

  task automatic test_illegal();
    logic vl, er;
    logic [31:0] rd;
    xact(1'b0, 3'b011, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (vl !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL load_f3_011: got vld=%b err=%b rdata=%h, want 1/1/00000000", vl, er, rd);
    end
    xact(1'b0, 3'b110, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL load_f3_110: got err=%b rdata=%h, want 1/00000000", er, rd);
    end
    xact(1'b1, 3'b100, 32'h10, 32'h0000_0055, vl, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL store_f3_100: got err=%b rdata=%h, want 1/00000000", er, rd);
    end
    xact(1'b0, 3'b010, 32'h10, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'h1234_AA22 || er !== 1'b0) begin
      errors++;
      $display("FAIL illegal_store_no_write: got rdata=%h err=%b, want 1234aa22/0", rd, er);
    end
  endtask

  task automatic test_wrap();
    logic vl, er;
    logic [31:0] rd;
    xact(1'b1, 3'b010, 32'd4096 + 32'd8, 32'hCAFE_0008, vl, rd, er);
    xact(1'b0, 3'b010, 32'h8, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'hCAFE_0008 || er !== 1'b0) begin
      errors++;
      $display("FAIL wrap_0x8: got rdata=%h err=%b, want cafe0008/0", rd, er);
    end
    xact(1'b0, 3'b010, 32'h8000_0008, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'hCAFE_0008) begin
      errors++;
      $display("FAIL wrap_high_addr: got rdata=%h, want cafe0008", rd);
    end
  endtask

  task automatic test_reset_pending();
    logic vl, er;
    logic [31:0] rd;
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h8;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_0008) begin
      errors++;
      $display("FAIL pending_before_reset: got vld=%b rdata=%h, want 1/cafe0008",
               bus.rsp_valid, bus.rsp_rdata);
    end
    rst_n          = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h8;
    bus.req_wdata  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: got vld=%b rdata=%h err=%b rdy=%b, want 0/00000000/0/1",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    xact(1'b0, 3'b010, 32'h8, 32'd0, vl, rd, er);
    checks++;
    if (rd !== 32'hCAFE_0008 || er !== 1'b0) begin
      errors++;
      $display("FAIL mem_kept_over_reset: got rdata=%h err=%b, want cafe0008/0", rd, er);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_word();
    test_subword_load();
    test_partial_store();
    test_back_to_back();
    test_backpressure();
    test_misalign();
    test_illegal();
    test_wrap();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
